gpu_port_cmd_decoder: RTL and testbench

//  Fabric-side consumer of the 32-bit gpu_port software control register.
//  - Filters the register for multi-bit stability, then exposes a level enable.
//  - Turns each change of an 8-bit sequence field into one opcode/argument command.
//  - Delivers that command to the GPU output packetiser over a valid/ready handshake.

---
 rtl/gpu_port_pkg.sv | 39 +++
 rtl/gpu_port_stable_filter.sv | 45 ++++
 rtl/gpu_port_cmd_decoder.sv | 152 +++++++++++++++
 tb/tb_gpu_port_cmd_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_port_pkg.sv
// Field map, opcode and state types shared by the gpu_port command decoder.
package gpu_port_pkg;

    localparam int EN_BIT = 31;
    localparam int SEQ_HI = 23;
    localparam int SEQ_LO = 16;
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int ARG_HI = 11;
    localparam int ARG_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0, OP_FILL  = 4'h1, OP_COPY  = 4'h2, OP_BLIT  = 4'h3,
        OP_FENCE = 4'h4, OP_DRAW  = 4'h5, OP_SYNC  = 4'h6, OP_IRQ   = 4'h7,
        OP_RSV8  = 4'h8, OP_RSV9  = 4'h9, OP_RSVA  = 4'hA, OP_RSVB  = 4'hB,
        OP_RSVC  = 4'hC, OP_RSVD  = 4'hD, OP_RSVE  = 4'hE, OP_RSVF  = 4'hF
    } gpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } gpu_state_e;

    typedef struct packed {
        logic [7:0]  seq;
        gpu_op_e     op;
        logic [11:0] arg;
    } gpu_cmd_t;

    function automatic gpu_cmd_t unpack_cmd(input logic [SEQ_HI:0] w);
        gpu_cmd_t c;
        c.seq = w[SEQ_HI:SEQ_LO];
        c.op  = gpu_op_e'(w[OP_HI:OP_LO]);
        c.arg = w[ARG_HI:ARG_LO];
        return c;
    endfunction

endpackage

// File: rtl/gpu_port_stable_filter.sv
// Multi-bit stability filter: a word is accepted once it has been sampled
// STABLE_CYCLES+1 times in a row; o_word_upd flags the edge that accepts it.
module gpu_port_stable_filter #(
    parameter int W             = 32,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_word_q,
    output logic [W-1:0] o_word_nxt,
    output logic         o_word_upd
);

    localparam int            CW     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] C_SAT  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]  r_samp;
    logic [W-1:0]  r_word_q;
    logic [CW-1:0] r_cnt;
    logic          w_eq;

    assign w_eq       = (i_data == r_samp);
    assign o_word_upd = w_eq && (r_cnt == C_LAST);
    assign o_word_q   = r_word_q;
    assign o_word_nxt = r_samp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_samp   <= '0;
            r_cnt    <= '0;
            r_word_q <= '0;
        end else begin
            r_samp <= i_data;
            if (!w_eq)
                r_cnt <= '0;
            else if (r_cnt != C_SAT)
                r_cnt <= r_cnt + CW'(1);
            if (o_word_upd)
                r_word_q <= r_samp;
        end
    end

endmodule

// File: rtl/gpu_port_cmd_decoder.sv
// Turns sequence-field changes of the gpu_port register into valid/ready commands.
// Define GPU_PORT_CMD_STATS_EN for live cmd_count/ovr_count counters.
//
// state   | meaning
// IDLE    | waiting for a pending command
// ISSUE   | cmd_valid high, cmd_* frozen until cmd_ready
// HOLDOFF | forced gap of HOLDOFF_CYCLES after a handshake
module gpu_port_cmd_decoder
    import gpu_port_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] reg_in,
    output logic        gpu_en,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [3:0]  cmd_op,
    output logic [11:0] cmd_arg,
    output logic [7:0]  cmd_seq,
    output logic [15:0] cmd_count,
    output logic [15:0] ovr_count
);

    localparam int HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

    logic [31:0] w_word_q;
    logic [31:0] w_word_nxt;
    logic        w_word_upd;
    gpu_cmd_t    w_new;
    logic        w_new_cmd;
    logic        w_take;
    logic        w_hs;
    logic        w_ovr;
    logic        w_unused;

    gpu_state_e  r_state;
    gpu_state_e  w_state_nxt;
    gpu_cmd_t    r_pend;
    gpu_cmd_t    r_cmd;
    logic        r_pend_valid;
    logic        r_base_done;
    logic [7:0]  r_last_seq;
    logic [HW-1:0] r_hold;

    gpu_port_stable_filter #(
        .W             (32),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .i_clk      (user_clk),
        .i_rst_n    (user_rst_n),
        .i_data     (reg_in),
        .o_word_q   (w_word_q),
        .o_word_nxt (w_word_nxt),
        .o_word_upd (w_word_upd)
    );

    // Reserved bits and the unregistered half of the filter output are not consumed.
    assign w_unused = ^{w_word_q[30:0], w_word_nxt[31:24]};

    assign w_new     = unpack_cmd(w_word_nxt[SEQ_HI:0]);
    assign w_new_cmd = w_word_upd && r_base_done && (w_new.seq != r_last_seq);
    assign w_take    = (r_state == ST_IDLE) && r_pend_valid;
    assign w_hs      = (r_state == ST_ISSUE) && cmd_ready;
    assign w_ovr     = w_new_cmd && r_pend_valid && !w_take;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_base_done  <= 1'b0;
            r_last_seq   <= '0;
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
            r_cmd        <= '0;
            r_hold       <= '0;
        end else begin
            if (w_word_upd && (!r_base_done || (w_new.seq != r_last_seq))) begin
                r_base_done <= 1'b1;
                r_last_seq  <= w_new.seq;
            end
            if (w_new_cmd) begin
                r_pend_valid <= 1'b1;
                r_pend       <= w_new;
            end else if (w_take) begin
                r_pend_valid <= 1'b0;
            end
            if (w_take)
                r_cmd <= r_pend;
            if (w_hs)
                r_hold <= HW'(HOLD_LOAD);
            else if ((r_state == ST_HOLDOFF) && (r_hold != '0))
                r_hold <= r_hold - HW'(1);
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (r_pend_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   if (cmd_ready)
                            w_state_nxt = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
            ST_HOLDOFF: if (r_hold == '0) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        if (r_state == ST_ISSUE)
            cmd_valid = 1'b1;
    end

    assign gpu_en  = w_word_q[EN_BIT];
    assign cmd_op  = r_cmd.op;
    assign cmd_arg = r_cmd.arg;
    assign cmd_seq = r_cmd.seq;

`ifdef GPU_PORT_CMD_STATS_EN
    logic [15:0] r_cmd_cnt;
    logic [15:0] r_ovr_cnt;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_cmd_cnt <= '0;
            r_ovr_cnt <= '0;
        end else begin
            if (w_hs && (r_cmd_cnt != 16'hFFFF))
                r_cmd_cnt <= r_cmd_cnt + 16'd1;
            if (w_ovr && (r_ovr_cnt != 16'hFFFF))
                r_ovr_cnt <= r_ovr_cnt + 16'd1;
        end
    end

    assign cmd_count = r_cmd_cnt;
    assign ovr_count = r_ovr_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_ovr;
    assign cmd_count      = '0;
    assign ovr_count      = '0;
`endif

endmodule

// File: tb/tb_gpu_port_cmd_decoder.sv
// Bench for gpu_port_cmd_decoder: directed scenarios plus random register traffic
// checked every cycle against a behavioural model.
module tb_gpu_port_cmd_decoder;

    localparam int STABLE = 4;
    localparam int HOLD   = 2;

    logic        user_clk   = 1'b0;
    logic        user_rst_n = 1'b0;
    logic [31:0] reg_in     = '0;
    logic        cmd_ready  = 1'b0;
    logic        gpu_en;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_arg;
    logic [7:0]  cmd_seq;
    logic [15:0] cmd_count;
    logic [15:0] ovr_count;

    gpu_port_cmd_decoder #(
        .STABLE_CYCLES  (STABLE),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .reg_in     (reg_in),
        .gpu_en     (gpu_en),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cmd_seq    (cmd_seq),
        .cmd_count  (cmd_count),
        .ovr_count  (ovr_count)
    );

    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word is accepted once STABLE+1 consecutive equal samples
    // have been seen (the reset value 0 counts as a prior sample).
    logic [31:0] m_prev, m_word, m_pdata, m_cmd;
    logic [7:0]  m_last;
    logic        m_base, m_pend, m_valid;
    int          m_run, m_edge, m_free_at, m_ccnt, m_ocnt;
    logic        m_upd, m_hs, m_take, m_pre_pend;

    always @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            m_prev = '0; m_word = '0; m_pdata = '0; m_cmd = '0; m_last = '0;
            m_base = 1'b0; m_pend = 1'b0; m_valid = 1'b0;
            m_run = 1; m_edge = 0; m_free_at = 0; m_ccnt = 0; m_ocnt = 0;
        end else begin
            m_edge++;
            m_upd = 1'b0;
            if (reg_in == m_prev) begin
                if (m_run <= STABLE) begin
                    m_run++;
                    if (m_run == STABLE + 1) m_upd = 1'b1;
                end
            end else begin
                m_run = 1;
            end
            m_prev     = reg_in;
            m_hs       = m_valid && cmd_ready;
            m_take     = !m_valid && m_pend && (m_edge >= m_free_at);
            m_pre_pend = m_pend;
            if (m_hs) begin
                m_valid   = 1'b0;
                if (m_ccnt < 65535) m_ccnt++;
                m_free_at = m_edge + HOLD + 1;
            end
            if (m_take) begin
                m_valid = 1'b1;
                m_cmd   = m_pdata;
                m_pend  = 1'b0;
            end
            if (m_upd) begin
                m_word = reg_in;
                if (!m_base) begin
                    m_base = 1'b1;
                    m_last = reg_in[23:16];
                end else if (reg_in[23:16] != m_last) begin
                    m_last = reg_in[23:16];
                    if (m_pre_pend && !m_take && m_ocnt < 65535) m_ocnt++;
                    m_pend  = 1'b1;
                    m_pdata = reg_in;
                end
            end
        end
    end

    logic [7:0] hs_log[$];

    always @(negedge user_clk) begin
        #3;
        if (user_rst_n) begin
            check("en", 32'(gpu_en), 32'(m_word[31]));
            check("valid", 32'(cmd_valid), 32'(m_valid));
            if (m_valid) begin
                check("op",  32'(cmd_op),  32'(m_cmd[15:12]));
                check("arg", 32'(cmd_arg), 32'(m_cmd[11:0]));
                check("seq", 32'(cmd_seq), 32'(m_cmd[23:16]));
            end
`ifdef GPU_PORT_CMD_STATS_EN
            check("cmd_count", 32'(cmd_count), 32'(m_ccnt));
            check("ovr_count", 32'(ovr_count), 32'(m_ocnt));
`else
            check("cmd_count", 32'(cmd_count), 32'h0);
            check("ovr_count", 32'(ovr_count), 32'h0);
`endif
            if (cmd_valid && cmd_ready) hs_log.push_back(cmd_seq);
        end
    end

    task automatic do_reset(input logic [31:0] val);
        @(negedge user_clk);
        user_rst_n = 1'b0;
        reg_in     = val;
        cmd_ready  = 1'b0;
        repeat (2) @(negedge user_clk);
        user_rst_n = 1'b1;
    endtask

    task automatic hold_word(input logic [31:0] val, input int n);
        @(negedge user_clk);
        reg_in = val;
        repeat (n - 1) @(negedge user_clk);
    endtask

    int          n_valid_seen;
    logic        seen;
    logic [31:0] rw;
    logic [7:0]  rseq;

    initial begin
        // 1: baseline after reset, gpu_en after five edges
        reg_in = 32'h8001_5123;
        repeat (2) @(negedge user_clk);
        user_rst_n = 1'b1;
        repeat (4) @(posedge user_clk);
        #1 check("t1_en_edge4", 32'(gpu_en), 32'h0);
        @(posedge user_clk);
        #1 check("t1_en_edge5", 32'(gpu_en), 32'h1);
        n_valid_seen = 0;
        repeat (6) begin
            @(posedge user_clk);
            #1 if (cmd_valid) n_valid_seen++;
        end
        check("t1_no_cmd", 32'(n_valid_seen), 32'h0);

        // 2: one command, valid after the sixth edge
        @(negedge user_clk);
        reg_in    = 32'h8002_5123;
        cmd_ready = 1'b1;
        repeat (5) @(posedge user_clk);
        #1 check("t2_valid_edge5", 32'(cmd_valid), 32'h0);
        @(posedge user_clk);
        #1 check("t2_valid_edge6", 32'(cmd_valid), 32'h1);
        check("t2_op",  32'(cmd_op),  32'h5);
        check("t2_arg", 32'(cmd_arg), 32'h123);
        check("t2_seq", 32'(cmd_seq), 32'h02);
        @(posedge user_clk);
        #1 check("t2_valid_drop", 32'(cmd_valid), 32'h0);
`ifdef GPU_PORT_CMD_STATS_EN
        check("t2_count", 32'(cmd_count), 32'h1);
`else
        check("t2_count", 32'(cmd_count), 32'h0);
`endif

        // 3: toggling faster than the filter window never produces a command
        n_valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            hold_word((i % 2 == 0) ? 32'h8003_5123 : 32'h8002_5123, 2);
        end
        repeat (10) begin
            @(posedge user_clk);
            #1 if (cmd_valid) n_valid_seen++;
        end
        check("t3_no_cmd", 32'(n_valid_seen), 32'h0);

        // 4 (and 6 without stats): overwrite of a pending command while stalled
        do_reset(32'h8001_5123);
        repeat (8) @(negedge user_clk);
        hs_log.delete();
        hold_word(32'h8002_7ABC, 6);
        hold_word(32'h8003_8DEF, 6);
        hold_word(32'h8004_9111, 6);
        check("t4_valid_stalled", 32'(cmd_valid), 32'h1);
        check("t4_seq_stalled", 32'(cmd_seq), 32'h02);
`ifdef GPU_PORT_CMD_STATS_EN
        check("t4_ovr", 32'(ovr_count), 32'h1);
`else
        check("t4_ovr", 32'(ovr_count), 32'h0);
`endif
        @(negedge user_clk);
        cmd_ready = 1'b1;
        repeat (12) @(negedge user_clk);
        check("t4_n_cmds", 32'(hs_log.size()), 32'h2);
        if (hs_log.size() == 2) begin
            check("t4_first",  32'(hs_log[0]), 32'h02);
            check("t4_second", 32'(hs_log[1]), 32'h04);
        end
`ifdef GPU_PORT_CMD_STATS_EN
        check("t4_count", 32'(cmd_count), 32'h2);
`else
        check("t4_count", 32'(cmd_count), 32'h0);
`endif

        // 5: 0xFF -> 0x00 wrap, then reset while the command is offered
        hold_word(32'h80FF_2001, 12);
        @(negedge user_clk);
        cmd_ready = 1'b0;
        reg_in    = 32'h8000_3002;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge user_clk);
            #1 if (cmd_valid) seen = 1'b1;
        end
        check("t5_wrap_cmd_seen", 32'(seen), 32'h1);
        check("t5_wrap_seq", 32'(cmd_seq), 32'h00);
        #1 user_rst_n = 1'b0;
        #1 check("t5_async_drop", 32'(cmd_valid), 32'h0);
        repeat (2) @(negedge user_clk);
        user_rst_n = 1'b1;
        cmd_ready  = 1'b1;
        n_valid_seen = 0;
        repeat (20) begin
            @(posedge user_clk);
            #1 if (cmd_valid) n_valid_seen++;
        end
        check("t5_no_replay", 32'(n_valid_seen), 32'h0);
        check("t5_en_back", 32'(gpu_en), 32'h1);

        // Random traffic checked by the model every cycle
        do_reset(32'h0000_0000);
        rseq = 8'h00;
        for (int s = 0; s < 120; s++) begin
            rw = $urandom;
            case ($urandom_range(0, 3))
                0:       rw[23:16] = rseq;
                1, 2:    rw[23:16] = rseq + 8'd1;
                default: ;
            endcase
            rseq = rw[23:16];
            for (int c = $urandom_range(1, 8); c > 0; c--) begin
                @(negedge user_clk);
                reg_in    = rw;
                cmd_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge user_clk);
        cmd_ready = 1'b1;
        repeat (20) @(negedge user_clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1);
    end

endmodule
